branch_predict_resolve: RTL

Parametrised successor to the EX-stage branch/jump controller. It resolves branch and jump outcomes the same way: RV32 func_3 conditions from the ALU flags, and targets from the branch adder or the ALU jump result. It also adds a direct-mapped branch target buffer with saturating direction counters, so IF predicts next-PC and EX flags mispredictions. It sits between the IF PC mux and the EX stage and drives the pipeline flush.

---
 rtl/branch_predict_resolve.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/branch_predict_resolve.sv
// branch_predict_resolve
//   EX-stage branch/jump resolution plus a direct-mapped branch target buffer (BTB)
//   with saturating direction counters. IF looks up fetch_pc_i combinationally.
//   EX resolves the RV32 branch condition from ALU flags, flags mispredictions
//   and trains the BTB on the next clock edge.
//
// Optional feature: define BPU_STATS_EN to build saturating 32-bit statistics
// counters. When it is undefined, the stat outputs are tied to zero.
//
// Ports
//   clk_i, rst_ni             clock (rising edge), asynchronous active-low reset
//   fetch_pc_i                IF-stage PC to look up
//   pred_taken_o/target_o     BTB prediction for fetch_pc_i (target 0 on miss)
//   resolve_valid_i/pc_i      EX instruction valid and its PC
//   func_3_i                  branch condition (RV32 funct3)
//   branch_signal_i           EX instruction is a conditional branch
//   jump_signal_i             EX instruction is an unconditional jump
//   zero/sign_bit/sltu_bit_signal_i  ALU flags
//   branch_address_i          branch adder target
//   alu_jump_imm_i            jump target from ALU
//   ex_pred_taken/target_i    prediction carried down the pipe
//   mispredict_o              flush IF/ID and load redirect_pc_o
//   redirect_pc_o             correct next PC
//   stat_branches_o           resolved control-instruction count
//   stat_mispredicts_o        misprediction count
module branch_predict_resolve #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned ENTRIES = 16,
  parameter int unsigned CTR_W   = 2
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [ADDR_W-1:0] fetch_pc_i,
  output logic              pred_taken_o,
  output logic [ADDR_W-1:0] pred_target_o,
  input  logic              resolve_valid_i,
  input  logic [ADDR_W-1:0] resolve_pc_i,
  input  logic [2:0]        func_3_i,
  input  logic              branch_signal_i,
  input  logic              jump_signal_i,
  input  logic              zero_signal_i,
  input  logic              sign_bit_signal_i,
  input  logic              sltu_bit_signal_i,
  input  logic [ADDR_W-1:0] branch_address_i,
  input  logic [ADDR_W-1:0] alu_jump_imm_i,
  input  logic              ex_pred_taken_i,
  input  logic [ADDR_W-1:0] ex_pred_target_i,
  output logic              mispredict_o,
  output logic [ADDR_W-1:0] redirect_pc_o,
  output logic [31:0]       stat_branches_o,
  output logic [31:0]       stat_mispredicts_o
);

  localparam int unsigned IDX_W = $clog2(ENTRIES);
  localparam int unsigned TAG_W = ADDR_W - IDX_W - 2;

  localparam logic [CTR_W-1:0] CtrMax    = {CTR_W{1'b1}};
  localparam logic [CTR_W-1:0] CtrZero   = {CTR_W{1'b0}};
  localparam logic [CTR_W-1:0] CtrWeakT  = {1'b1, {(CTR_W-1){1'b0}}};
  localparam logic [CTR_W-1:0] CtrWeakNt = {1'b0, {(CTR_W-1){1'b1}}};

  logic              valid_q  [ENTRIES];
  logic [TAG_W-1:0]  tag_q    [ENTRIES];
  logic [ADDR_W-1:0] target_q [ENTRIES];
  logic              jump_q   [ENTRIES];
  logic [CTR_W-1:0]  ctr_q    [ENTRIES];

  // Lookup
  logic [IDX_W-1:0] f_idx;
  logic [TAG_W-1:0] f_tag;
  logic             f_hit;

  assign f_idx = fetch_pc_i[IDX_W+1:2];
  assign f_tag = fetch_pc_i[ADDR_W-1:IDX_W+2];
  assign f_hit = valid_q[f_idx] && (tag_q[f_idx] == f_tag);

  assign pred_taken_o  = f_hit & (jump_q[f_idx] | ctr_q[f_idx][CTR_W-1]);
  assign pred_target_o = f_hit ? target_q[f_idx] : '0;

  // Resolution
  logic              cond;
  logic              actual_taken;
  logic [ADDR_W-1:0] actual_target;
  logic              ctl;

  always_comb begin
    cond = 1'b0;
    case (func_3_i)
      3'b000:  cond = zero_signal_i;
      3'b001:  cond = ~zero_signal_i;
      3'b100:  cond = ~zero_signal_i & sign_bit_signal_i;
      3'b101:  cond = ~sign_bit_signal_i;
      3'b110:  cond = ~zero_signal_i & sltu_bit_signal_i;
      3'b111:  cond = ~sltu_bit_signal_i;
      default: cond = 1'b0;
    endcase
  end

  assign actual_taken  = jump_signal_i | (branch_signal_i & cond);
  assign actual_target = jump_signal_i ? alu_jump_imm_i : branch_address_i;
  assign ctl           = resolve_valid_i & (branch_signal_i | jump_signal_i);

  // A non-control instruction that was predicted taken also mispredicts.
  assign mispredict_o = resolve_valid_i &
                        ((actual_taken != ex_pred_taken_i) |
                         (actual_taken & (ex_pred_target_i != actual_target)));
  assign redirect_pc_o = actual_taken ? actual_target : resolve_pc_i + ADDR_W'(4);

  // Training
  logic [IDX_W-1:0] r_idx;
  logic [TAG_W-1:0] r_tag;
  logic             r_hit;
  logic             wr_en;
  logic [CTR_W-1:0] ctr_d;

  assign r_idx = resolve_pc_i[IDX_W+1:2];
  assign r_tag = resolve_pc_i[ADDR_W-1:IDX_W+2];
  assign r_hit = valid_q[r_idx] && (tag_q[r_idx] == r_tag);
  // Misses that resolve not-taken leave the BTB alone.
  assign wr_en = ctl & (r_hit | actual_taken);

  always_comb begin
    ctr_d = ctr_q[r_idx];
    if (!r_hit) begin
      ctr_d = CtrWeakT;
    end else if (actual_taken) begin
      if (ctr_q[r_idx] != CtrMax) ctr_d = ctr_q[r_idx] + CTR_W'(1);
    end else begin
      if (ctr_q[r_idx] != CtrZero) ctr_d = ctr_q[r_idx] - CTR_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < ENTRIES; i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        jump_q[i]   <= 1'b0;
        ctr_q[i]    <= CtrWeakNt;
      end
    end else if (wr_en) begin
      valid_q[r_idx]  <= 1'b1;
      tag_q[r_idx]    <= r_tag;
      target_q[r_idx] <= actual_target;
      jump_q[r_idx]   <= jump_signal_i;
      ctr_q[r_idx]    <= ctr_d;
    end
  end

`ifdef BPU_STATS_EN
  logic [31:0] stat_branches_q, stat_mispredicts_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stat_branches_q    <= '0;
      stat_mispredicts_q <= '0;
    end else begin
      if (ctl && (stat_branches_q != 32'hFFFF_FFFF)) begin
        stat_branches_q <= stat_branches_q + 32'd1;
      end
      if (mispredict_o && (stat_mispredicts_q != 32'hFFFF_FFFF)) begin
        stat_mispredicts_q <= stat_mispredicts_q + 32'd1;
      end
    end
  end

  assign stat_branches_o    = stat_branches_q;
  assign stat_mispredicts_o = stat_mispredicts_q;
`else
  assign stat_branches_o    = 32'd0;
  assign stat_mispredicts_o = 32'd0;
`endif

  // Byte-offset bits of the fetch PC do not take part in the lookup.
  logic unused_fetch_lsb;
  assign unused_fetch_lsb = ^fetch_pc_i[1:0];

endmodule
